id_stage: RTL and testbench

Decode-side neighbour of the instruction-fetch stage in the 5-stage MIPS pipeline.
- Holds the IF/ID pipeline register.
- Resolves branches and jumps in ID and drives redirect (Branch_Jump, PC_Update) plus fetch Enable back to IF.
- Passes PC, instruction, valid and link address to the ID/EX logic.
- Operand values arrive already forwarded; no register file in this block.

---
 rtl/id_pkg.sv | 54 +++++
 rtl/id_branch_unit.sv | 64 ++++++
 rtl/id_stage.sv | 114 +++++++++++
 tb/tb_id_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// id_pkg: shared constants and types for the MIPS decode stage.
// Holds opcode/funct encodings, reset defaults and the branch-class decoder.
package id_pkg;

  // Reset defaults for the IF/ID register
  localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // Primary opcode field values (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;

  // SPECIAL funct field values (instr[5:0])
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  // Control-transfer class of the instruction sitting in ID
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_J    = 3'd3,
    BR_JAL  = 3'd4,
    BR_JR   = 3'd5,
    BR_JALR = 3'd6
  } br_class_e;

  // Classify an instruction from its opcode and funct fields.
  // Anything that is not a recognised control transfer maps to BR_NONE.
  function automatic br_class_e decode_branch(input logic [5:0] op,
                                              input logic [5:0] funct);
    br_class_e cls;
    cls = BR_NONE;
    case (op)
      OP_BEQ: cls = BR_BEQ;
      OP_BNE: cls = BR_BNE;
      OP_J:   cls = BR_J;
      OP_JAL: cls = BR_JAL;
      OP_SPECIAL: begin
        case (funct)
          FN_JR:   cls = BR_JR;
          FN_JALR: cls = BR_JALR;
          default: cls = BR_NONE;
        endcase
      end
      default: cls = BR_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/id_branch_unit.sv
// id_branch_unit: combinational branch/jump resolver for the ID stage.
// Decodes the ID instruction, evaluates the branch condition on the
// forwarded operands and produces the redirect target. All arithmetic
// wraps mod 2^32.
module id_branch_unit
  import id_pkg::*;
(
  input  logic [31:0] ID_PC,
  input  logic [31:0] ID_Instr,
  input  logic [31:0] RS_Data,
  input  logic [31:0] RT_Data,
  output logic        taken,
  output logic [31:0] target
);

  br_class_e   br_class_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] br_offset_s;
  logic [31:0] br_target_s;
  logic [31:0] jmp_target_s;
  logic        rs_eq_rt_s;

  assign br_class_s   = decode_branch(ID_Instr[31:26], ID_Instr[5:0]);
  assign pc_plus4_s   = ID_PC + 32'd4;
  // Word offset: sign-extended imm16 shifted left by two
  assign br_offset_s  = {{14{ID_Instr[15]}}, ID_Instr[15:0], 2'b00};
  assign br_target_s  = pc_plus4_s + br_offset_s;
  // Pseudo-direct jump keeps the 256 MB region of the delay-slot PC
  assign jmp_target_s = {pc_plus4_s[31:28], ID_Instr[25:0], 2'b00};
  assign rs_eq_rt_s   = (RS_Data == RT_Data);

  // Select condition and target according to the decoded class
  always_comb begin
    taken  = 1'b0;
    target = 32'd0;
    case (br_class_s)
      BR_BEQ: begin
        taken  = rs_eq_rt_s;
        target = br_target_s;
      end
      BR_BNE: begin
        taken  = ~rs_eq_rt_s;
        target = br_target_s;
      end
      BR_J, BR_JAL: begin
        taken  = 1'b1;
        target = jmp_target_s;
      end
      BR_JR, BR_JALR: begin
        taken  = 1'b1;
        target = RS_Data;
      end
      BR_NONE: begin
        taken  = 1'b0;
        target = 32'd0;
      end
      default: begin
        taken  = 1'b0;
        target = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID pipeline register plus branch/jump resolution in ID.
// Drives fetch enable and the redirect (Branch_Jump/PC_Update) back to IF
// and hands PC, instruction, valid and link address to the ID/EX logic.
// Optional build macro ID_FLUSH_EN: removes the delay slot by squashing the
// wrong-path fetch on a redirect; link address becomes ID_PC + 4.
module id_stage
  import id_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_Instr,
  input  logic        Stall,
  input  logic [31:0] RS_Data,
  input  logic [31:0] RT_Data,
  output logic        Enable,
  output logic        Branch_Jump,
  output logic [31:0] PC_Update,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_Instr,
  output logic        ID_Valid,
  output logic [31:0] Link_Addr
);

`ifdef ID_FLUSH_EN
  // No delay slot: return lands on the instruction after the call
  localparam logic [31:0] LINK_OFS = 32'd4;
`else
  // Delay slot executes, so return skips past it
  localparam logic [31:0] LINK_OFS = 32'd8;
`endif

  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;

  logic        bu_taken_s;
  logic [31:0] bu_target_s;
  logic        branch_jump_s;

  id_branch_unit u_branch_unit (
    .ID_PC    (id_pc_q),
    .ID_Instr (id_instr_q),
    .RS_Data  (RS_Data),
    .RT_Data  (RT_Data),
    .taken    (bu_taken_s),
    .target   (bu_target_s)
  );

  // A stalled cycle never redirects; the decision is re-made once it clears
  assign branch_jump_s = bu_taken_s & id_valid_q & ~Stall;

  // IF/ID next-state: hold on stall, otherwise load the fetched instruction
  always_comb begin
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (Stall) begin
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
    end else begin
`ifdef ID_FLUSH_EN
      if (branch_jump_s) begin
        // Squash the wrong-path fetch; keep its PC for traceability
        id_pc_d    = IF_PC;
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end else begin
        id_pc_d    = IF_PC;
        id_instr_d = IF_Instr;
        id_valid_d = 1'b1;
      end
`else
      id_pc_d    = IF_PC;
      id_instr_d = IF_Instr;
      id_valid_d = 1'b1;
`endif
    end
  end

  // IF/ID register with asynchronous active-low reset to a bubble
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      id_pc_q    <= PC_RESET;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Redirect and fetch-control outputs toward IF
  always_comb begin
    Enable      = ~Stall;
    Branch_Jump = branch_jump_s;
    if (branch_jump_s) begin
      PC_Update = bu_target_s;
    end else begin
      PC_Update = 32'd0;
    end
  end

  assign ID_PC     = id_pc_q;
  assign ID_Instr  = id_instr_q;
  assign ID_Valid  = id_valid_q;
  assign Link_Addr = id_pc_q + LINK_OFS;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: self-checking bench for id_stage.
// Table of single-instruction vectors fed through a scoreboard queue, plus
// hand-written sequences for reset, stall and delay-slot/flush behaviour.
module tb_id_stage;

`ifdef ID_FLUSH_EN
  localparam logic [31:0] LINK_OFS = 32'd4;
  localparam bit          FLUSH    = 1'b1;
`else
  localparam logic [31:0] LINK_OFS = 32'd8;
  localparam bit          FLUSH    = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instr;
  logic        Stall;
  logic [31:0] RS_Data;
  logic [31:0] RT_Data;
  logic        Enable;
  logic        Branch_Jump;
  logic [31:0] PC_Update;
  logic [31:0] ID_PC;
  logic [31:0] ID_Instr;
  logic        ID_Valid;
  logic [31:0] Link_Addr;

  id_stage dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .IF_PC       (IF_PC),
    .IF_Instr    (IF_Instr),
    .Stall       (Stall),
    .RS_Data     (RS_Data),
    .RT_Data     (RT_Data),
    .Enable      (Enable),
    .Branch_Jump (Branch_Jump),
    .PC_Update   (PC_Update),
    .ID_PC       (ID_PC),
    .ID_Instr    (ID_Instr),
    .ID_Valid    (ID_Valid),
    .Link_Addr   (Link_Addr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        bj;
    logic [31:0] pcu;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bj;
    logic [31:0] pcu;
    logic [31:0] link;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Short async reset pulse between edges, leaving ID holding a bubble
  task automatic reset_pulse();
    Reset = 1'b0;
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{"beq_taken",   32'h0000_3004, 32'h1022_0003, 32'd5,         32'd5, 1'b1, 32'h0000_3014};
    vecs[1]  = '{"beq_nottkn",  32'h0000_3004, 32'h1022_0003, 32'd5,         32'd6, 1'b0, 32'h0000_0000};
    vecs[2]  = '{"bne_back",    32'h0000_3004, 32'h1422_FFFF, 32'd1,         32'd2, 1'b1, 32'h0000_3004};
    vecs[3]  = '{"bne_nottkn",  32'h0000_3004, 32'h1422_FFFF, 32'd7,         32'd7, 1'b0, 32'h0000_0000};
    vecs[4]  = '{"j",           32'h0000_3008, 32'h0800_0C05, 32'd0,         32'd0, 1'b1, 32'h0000_3014};
    vecs[5]  = '{"jal",         32'h0000_3008, 32'h0C00_0C05, 32'd0,         32'd0, 1'b1, 32'h0000_3014};
    vecs[6]  = '{"jr",          32'h0000_3020, 32'h0020_0008, 32'h0000_3040, 32'd0, 1'b1, 32'h0000_3040};
    vecs[7]  = '{"jalr",        32'h0000_3030, 32'h0020_F809, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678};
    vecs[8]  = '{"undef_addiu", 32'h0000_3040, 32'h2408_0001, 32'd3,         32'd3, 1'b0, 32'h0000_0000};
    vecs[9]  = '{"j_region",    32'hF000_0000, 32'h0BFF_FFFF, 32'd0,         32'd0, 1'b1, 32'hFFFF_FFFC};
    vecs[10] = '{"special_add", 32'h0000_3050, 32'h0022_1820, 32'd1,         32'd1, 1'b0, 32'h0000_0000};

    Reset    = 1'b0;
    Stall    = 1'b0;
    IF_PC    = 32'h0000_3000;
    IF_Instr = 32'h2408_0001;
    RS_Data  = 32'd0;
    RT_Data  = 32'd0;

    // Reset state while held in reset across clock edges
    tick();
    tick();
    chk("rst_id_pc",    ID_PC,              32'h0000_3000);
    chk("rst_id_instr", ID_Instr,           32'h0000_0000);
    chk("rst_id_valid", {31'd0, ID_Valid},  32'd0);
    chk("rst_bj",       {31'd0, Branch_Jump}, 32'd0);
    chk("rst_pcu",      PC_Update,          32'd0);
    chk("rst_enable",   {31'd0, Enable},    32'd1);

    // Table vectors: load one instruction into ID and check its resolution
    for (int i = 0; i < 11; i++) begin
      reset_pulse();
      IF_PC    = vecs[i].pc;
      IF_Instr = vecs[i].instr;
      RS_Data  = vecs[i].rs;
      RT_Data  = vecs[i].rt;
      Stall    = 1'b0;
      sb.push_back('{vecs[i].name, vecs[i].pc, vecs[i].instr, vecs[i].bj,
                     vecs[i].pcu, vecs[i].pc + LINK_OFS});
      tick();
      e = sb.pop_front();
      chk({e.name, "_id_pc"},    ID_PC,                 e.pc);
      chk({e.name, "_id_instr"}, ID_Instr,              e.instr);
      chk({e.name, "_id_valid"}, {31'd0, ID_Valid},     32'd1);
      chk({e.name, "_bj"},       {31'd0, Branch_Jump},  {31'd0, e.bj});
      chk({e.name, "_pcu"},      PC_Update,             e.pcu);
      chk({e.name, "_link"},     Link_Addr,             e.link);
      chk({e.name, "_enable"},   {31'd0, Enable},       32'd1);
    end
    chk("sb_drained", sb.size(), 32'd0);

    // Mid-run reset while a taken jump sits in ID
    reset_pulse();
    IF_PC    = 32'h0000_3010;
    IF_Instr = 32'h0800_0C05;
    tick();
    chk("mr_pre_id_pc", ID_PC,                32'h0000_3010);
    chk("mr_pre_bj",    {31'd0, Branch_Jump}, 32'd1);
    #1;
    Reset = 1'b0;
    #1;
    chk("mr_id_pc",    ID_PC,                32'h0000_3000);
    chk("mr_id_instr", ID_Instr,             32'h0000_0000);
    chk("mr_id_valid", {31'd0, ID_Valid},    32'd0);
    chk("mr_bj",       {31'd0, Branch_Jump}, 32'd0);
    chk("mr_pcu",      PC_Update,            32'd0);
    chk("mr_enable",   {31'd0, Enable},      32'd1);
    Reset    = 1'b1;
    IF_PC    = 32'h0000_3020;
    IF_Instr = 32'h2408_0001;
    tick();
    chk("mr_rel_id_pc",    ID_PC,             32'h0000_3020);
    chk("mr_rel_id_instr", ID_Instr,          32'h2408_0001);
    chk("mr_rel_id_valid", {31'd0, ID_Valid}, 32'd1);

    // Stall with a taken beq in ID: redirect held off, registers frozen
    reset_pulse();
    IF_PC    = 32'h0000_3004;
    IF_Instr = 32'h1022_0003;
    RS_Data  = 32'd5;
    RT_Data  = 32'd5;
    tick();
    chk("st_pre_bj", {31'd0, Branch_Jump}, 32'd1);
    Stall    = 1'b1;
    RT_Data  = 32'd6;
    IF_PC    = 32'h0000_3100;
    IF_Instr = 32'h2408_0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("st_enable", {31'd0, Enable},      32'd0);
      chk("st_bj",     {31'd0, Branch_Jump}, 32'd0);
      chk("st_pcu",    PC_Update,            32'd0);
      tick();
      chk("st_id_pc",    ID_PC,             32'h0000_3004);
      chk("st_id_instr", ID_Instr,          32'h1022_0003);
      chk("st_id_valid", {31'd0, ID_Valid}, 32'd1);
    end
    // Release with operands now unequal: no redirect
    Stall = 1'b0;
    #1;
    chk("st_rel_ne_bj",     {31'd0, Branch_Jump}, 32'd0);
    chk("st_rel_ne_enable", {31'd0, Enable},      32'd1);
    // Forwarded operand update makes them equal: redirect now fires
    RT_Data = 32'd5;
    #1;
    chk("st_rel_eq_bj",  {31'd0, Branch_Jump}, 32'd1);
    chk("st_rel_eq_pcu", PC_Update,            32'h0000_3014);

    // Delay slot vs. flush after a taken j
    reset_pulse();
    Stall    = 1'b0;
    IF_PC    = 32'h0000_3008;
    IF_Instr = 32'h0800_0C05;
    tick();
    chk("ds_j_bj",  {31'd0, Branch_Jump}, 32'd1);
    chk("ds_j_pcu", PC_Update,            32'h0000_3014);
    IF_PC    = 32'h0000_300C;
    IF_Instr = 32'h2408_0001;
    tick();
    chk("ds_slot_id_pc",    ID_PC,             32'h0000_300C);
    chk("ds_slot_id_instr", ID_Instr,          FLUSH ? 32'h0000_0000 : 32'h2408_0001);
    chk("ds_slot_id_valid", {31'd0, ID_Valid}, FLUSH ? 32'd0 : 32'd1);
    chk("ds_slot_bj",       {31'd0, Branch_Jump}, 32'd0);
    IF_PC    = 32'h0000_3014;
    IF_Instr = 32'h2409_0002;
    tick();
    chk("ds_tgt_id_pc",    ID_PC,             32'h0000_3014);
    chk("ds_tgt_id_instr", ID_Instr,          32'h2409_0002);
    chk("ds_tgt_id_valid", {31'd0, ID_Valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
